// File: rtl/reg_write_queue_if.sv
// Handshake, drain and forwarding signals between the write-back path,
// the register file write port and the read-side bypass.
interface reg_write_queue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic              drain_stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              fwd_hit1;
  logic [DATA_W-1:0] fwd_data1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data2;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_rd, in_data, drain_stall, rs, rt,
    input  in_ready, rf_we, rf_waddr, rf_wdata,
           fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
  );

  modport slave (
    input  in_valid, in_rd, in_data, drain_stall, rs, rt,
    output in_ready, rf_we, rf_waddr, rf_wdata,
           fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
  );
endinterface

// File: rtl/reg_write_queue.sv
// Register-file write queue: buffers write-back requests, drains one per
// cycle to the write port, and bypasses pending data to the read ports.
module reg_write_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input logic            clk,
  input logic            rst,
  reg_write_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              not_empty;
  logic              push;
  logic              pop;
  logic              hit1;
  logic              hit2;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [PTR_W-1:0]  idx;

  assign head      = mem[rd_ptr];
  assign not_empty = (cnt != '0);

  // Writes to $0 complete the handshake but are never stored.
  assign push = bus.in_valid & bus.in_ready & (bus.in_rd != '0);
  assign pop  = not_empty & ~bus.drain_stall;

  assign bus.in_ready = (cnt < CNT_W'(DEPTH));
  assign bus.rf_we    = pop;
  assign bus.rf_waddr = not_empty ? head.rd   : '0;
  assign bus.rf_wdata = not_empty ? head.data : '0;
  assign bus.count    = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      mem    <= '{default: '0};
    end else begin
      if (push) begin
        mem[wr_ptr] <= {bus.in_rd, bus.in_data};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Walk oldest to youngest so the youngest match overrides older ones.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    data1 = '0;
    data2 = '0;
    idx   = rd_ptr;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < cnt) begin
        if ((bus.rs != '0) && (mem[idx].rd == bus.rs)) begin
          hit1  = 1'b1;
          data1 = mem[idx].data;
        end
        if ((bus.rt != '0) && (mem[idx].rd == bus.rt)) begin
          hit2  = 1'b1;
          data2 = mem[idx].data;
        end
      end
    end
  end

  assign bus.fwd_hit1  = hit1;
  assign bus.fwd_data1 = data1;
  assign bus.fwd_hit2  = hit2;
  assign bus.fwd_data2 = data2;
endmodule

// File: tb/tb_reg_write_queue.sv
// Self-checking bench for reg_write_queue: directed vector table, hand-written
// full/reset sequences, and random traffic against a queue-based model.
module tb_reg_write_queue;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reg_write_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  reg_write_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        stall;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hit1;
    logic [31:0] d1;
    logic        hit2;
    logic [31:0] d2;
    logic [2:0]  cnt;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  vec_t vt[21];
  wr_t  mq[$];

  function automatic vec_t mk(input logic v, input logic [4:0] rd, input logic [31:0] d,
                              input logic st, input logic [4:0] a1, input logic [4:0] a2,
                              input logic rdy, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic h1, input logic [31:0] d1,
                              input logic h2, input logic [31:0] d2, input logic [2:0] c);
    vec_t r;
    r.valid = v;   r.rd = rd;   r.data = d;   r.stall = st; r.rs = a1;  r.rt = a2;
    r.ready = rdy; r.we = we;   r.waddr = wa; r.wdata = wd; r.hit1 = h1; r.d1 = d1;
    r.hit2 = h2;   r.d2 = d2;   r.cnt = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                       input logic st, input logic [4:0] a1, input logic [4:0] a2);
    bus.in_valid    = v;
    bus.in_rd       = rd;
    bus.in_data     = d;
    bus.drain_stall = st;
    bus.rs          = a1;
    bus.rt          = a2;
  endtask

  // Youngest pending write to addr, from the model queue.
  task automatic fwd_model(input logic [4:0] addr, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (addr != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].rd == addr) begin
          hit = 1'b1;
          d   = mq[i].data;
          break;
        end
      end
    end
  endtask

  // One clock of traffic checked against the model; starts and ends just after a rising edge.
  task automatic cycle(input logic v, input logic [4:0] rd, input logic [31:0] d,
                       input logic st, input logic [4:0] a1, input logic [4:0] a2);
    logic        h1, h2, do_pop, do_acc;
    logic [31:0] e1, e2;
    wr_t         w;
    drive(v, rd, d, st, a1, a2);
    @(negedge clk);
    fwd_model(a1, h1, e1);
    fwd_model(a2, h2, e2);
    chk("m_in_ready",  64'(bus.in_ready),  64'(mq.size() < DEPTH));
    chk("m_rf_we",     64'(bus.rf_we),     64'(mq.size() != 0 && !st));
    chk("m_rf_waddr",  64'(bus.rf_waddr),  64'(mq.size() != 0 ? mq[0].rd : 5'd0));
    chk("m_rf_wdata",  64'(bus.rf_wdata),  64'(mq.size() != 0 ? mq[0].data : 32'd0));
    chk("m_fwd_hit1",  64'(bus.fwd_hit1),  64'(h1));
    chk("m_fwd_data1", 64'(bus.fwd_data1), 64'(e1));
    chk("m_fwd_hit2",  64'(bus.fwd_hit2),  64'(h2));
    chk("m_fwd_data2", 64'(bus.fwd_data2), 64'(e2));
    chk("m_count",     64'(bus.count),     64'(mq.size()));
    do_pop = (mq.size() != 0) && !st;
    do_acc = v && (mq.size() < DEPTH);
    if (do_pop) void'(mq.pop_front());
    if (do_acc && rd != 0) begin
      w.rd = rd;
      w.data = d;
      mq.push_back(w);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    vt[0]  = mk(1, 5, 32'hA5A5A5A5, 0, 0, 0, 1, 0, 0, 0,            0, 0,            0, 0,      0);
    vt[1]  = mk(0, 0, 0,            0, 5, 0, 1, 1, 5, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 0, 0,      1);
    vt[2]  = mk(0, 0, 0,            0, 5, 0, 1, 0, 0, 0,            0, 0,            0, 0,      0);
    vt[3]  = mk(1, 1, 32'h101,      1, 0, 0, 1, 0, 0, 0,            0, 0,            0, 0,      0);
    vt[4]  = mk(1, 2, 32'h102,      1, 0, 0, 1, 0, 1, 32'h101,      0, 0,            0, 0,      1);
    vt[5]  = mk(1, 3, 32'h103,      1, 0, 0, 1, 0, 1, 32'h101,      0, 0,            0, 0,      2);
    vt[6]  = mk(1, 4, 32'h104,      1, 0, 0, 1, 0, 1, 32'h101,      0, 0,            0, 0,      3);
    vt[7]  = mk(1, 9, 32'h109,      1, 9, 4, 0, 0, 1, 32'h101,      0, 0,            1, 32'h104, 4);
    vt[8]  = mk(0, 0, 0,            0, 9, 0, 0, 1, 1, 32'h101,      0, 0,            0, 0,      4);
    vt[9]  = mk(0, 0, 0,            0, 9, 0, 1, 1, 2, 32'h102,      0, 0,            0, 0,      3);
    vt[10] = mk(0, 0, 0,            0, 0, 0, 1, 1, 3, 32'h103,      0, 0,            0, 0,      2);
    vt[11] = mk(0, 0, 0,            0, 0, 0, 1, 1, 4, 32'h104,      0, 0,            0, 0,      1);
    vt[12] = mk(0, 0, 0,            0, 9, 4, 1, 0, 0, 0,            0, 0,            0, 0,      0);
    vt[13] = mk(1, 7, 32'h11,       1, 0, 0, 1, 0, 0, 0,            0, 0,            0, 0,      0);
    vt[14] = mk(1, 7, 32'h22,       1, 7, 8, 1, 0, 7, 32'h11,       1, 32'h11,       0, 0,      1);
    vt[15] = mk(0, 0, 0,            1, 7, 8, 1, 0, 7, 32'h11,       1, 32'h22,       0, 0,      2);
    vt[16] = mk(0, 0, 0,            0, 7, 7, 1, 1, 7, 32'h11,       1, 32'h22,       1, 32'h22, 2);
    vt[17] = mk(0, 0, 0,            0, 7, 0, 1, 1, 7, 32'h22,       1, 32'h22,       0, 0,      1);
    vt[18] = mk(0, 0, 0,            0, 7, 0, 1, 0, 0, 0,            0, 0,            0, 0,      0);
    vt[19] = mk(1, 0, 32'hFFFF,     0, 0, 0, 1, 0, 0, 0,            0, 0,            0, 0,      0);
    vt[20] = mk(0, 0, 0,            0, 0, 0, 1, 0, 0, 0,            0, 0,            0, 0,      0);

    // Reset state
    @(negedge clk);
    chk("rst_count",    64'(bus.count),    64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_rf_we",    64'(bus.rf_we),    64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 21; i++) begin
      drive(vt[i].valid, vt[i].rd, vt[i].data, vt[i].stall, vt[i].rs, vt[i].rt);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i),  64'(bus.in_ready),  64'(vt[i].ready));
      chk($sformatf("v%0d_rf_we", i),     64'(bus.rf_we),     64'(vt[i].we));
      chk($sformatf("v%0d_rf_waddr", i),  64'(bus.rf_waddr),  64'(vt[i].waddr));
      chk($sformatf("v%0d_rf_wdata", i),  64'(bus.rf_wdata),  64'(vt[i].wdata));
      chk($sformatf("v%0d_fwd_hit1", i),  64'(bus.fwd_hit1),  64'(vt[i].hit1));
      chk($sformatf("v%0d_fwd_data1", i), 64'(bus.fwd_data1), 64'(vt[i].d1));
      chk($sformatf("v%0d_fwd_hit2", i),  64'(bus.fwd_hit2),  64'(vt[i].hit2));
      chk($sformatf("v%0d_fwd_data2", i), 64'(bus.fwd_data2), 64'(vt[i].d2));
      chk($sformatf("v%0d_count", i),     64'(bus.count),     64'(vt[i].cnt));
      @(posedge clk);
      #1;
    end

    // Full queue: pop plus refused push, then next push accepted; repeated to wrap pointers
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) cycle(1, 5'(10 + k), 32'(r * 16 + k), 1, 5'(10 + k), 0);
      cycle(1, 5'd20, 32'hDEAD, 0, 5'd20, 5'd10);
      chk("full_after_pop_count", 64'(bus.count), 64'd3);
      cycle(1, 5'd21, 32'(100 + r), 1, 5'd21, 5'd13);
      chk("full_next_push_count", 64'(bus.count), 64'd4);
      for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 5'd21, 5'd20);
    end

    // Reset between edges with three entries pending
    for (int k = 0; k < 3; k++) cycle(1, 5'(3 + k), 32'(32'h300 + k), 1, 0, 0);
    drive(0, 0, 0, 0, 5'd3, 5'd5);
    #2 rst = 1'b1;
    #1;
    chk("midrst_count",    64'(bus.count),    64'd0);
    chk("midrst_rf_we",    64'(bus.rf_we),    64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_fwd_hit1", 64'(bus.fwd_hit1), 64'd0);
    mq.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 5'd3, 5'd5);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
